// File: rtl/dcp_pkg.sv
// Shared definitions for the DCP print-path arbiter: FSM state type,
// default sizing and the command-unit index map.
package dcp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam int DCP_N_REQ = 4;
   localparam int DCP_DW    = 32;

   // Request-port index of each command unit.
   localparam int CU_D = 0;
   localparam int CU_I = 1;
   localparam int CU_R = 2;
   localparam int CU_P = 3;
   localparam int CU_T = 4;
   localparam int CU_B = 5;
   localparam int CU_G = 6;
   localparam int CU_L = 7;

endpackage

// File: rtl/dcp_tx_arb_rr_pick.sv
// Combinational round-robin picker: one-hot select of the first requester
// strictly after ptr, searching upward and wrapping.
module rr_pick
   import dcp_pkg::*;
#(
   parameter int N_REQ = DCP_N_REQ
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         pick
);

   int   idx;
   logic found;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dcp_tx_arb.sv
// Round-robin arbiter sharing one PRINT serializer among N_REQ command units.
// Optional hold watchdog is compiled in with DCP_TXARB_WDOG_EN.
module dcp_tx_arb
   import dcp_pkg::*;
#(
   parameter int N_REQ    = DCP_N_REQ,
   parameter int DW       = DCP_DW,
   parameter int WDOG_CYC = 1024
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ-1:0]    lock,
   input  logic [N_REQ-1:0]    typ,
   input  logic [N_REQ*DW-1:0] dout,
   output logic [N_REQ-1:0]    ack,
   output logic [N_REQ-1:0]    grant,
   output logic                req_tx,
   output logic                type_tx,
   output logic [DW-1:0]       dout_tx,
   input  logic                ack_tx,
   output logic                busy,
   output logic                timeout,
   output state_t              state_dbg
);

   localparam int PW = $clog2(N_REQ);

   // Handshake: the granted unit holds req until ack; a transfer completes on
   // the cycle XFER sees ack_tx with req_tx high, and ack mirrors that cycle.
   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d, g_q, g_d;
   logic [N_REQ-1:0] pick;
   logic [PW-1:0]   pick_idx;
   logic            g_req, g_lock, g_typ, xfer, done, wdog_hit;
   logic [DW-1:0]   g_dout;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req  (req),
      .ptr  (ptr_q),
      .pick (pick)
   );

   always_comb begin
      pick_idx = '0;
      g_dout   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick[i]) pick_idx = PW'(i);
         if (g_q == PW'(i)) g_dout = dout[i*DW +: DW];
      end
   end

   assign g_req   = req[g_q];
   assign g_lock  = lock[g_q];
   assign g_typ   = typ[g_q];
   assign xfer    = (state_q == ST_XFER);
   assign done    = xfer & ack_tx & g_req;

   assign req_tx    = xfer & g_req;
   assign type_tx   = xfer & g_typ;
   assign dout_tx   = xfer ? g_dout : '0;
   assign busy      = (state_q != ST_IDLE);
   assign state_dbg = state_q;

   always_comb begin
      grant = '0;
      if (state_q != ST_IDLE) grant[g_q] = 1'b1;
   end

   assign ack = done ? grant : '0;

`ifdef DCP_TXARB_WDOG_EN
   localparam int CW = $clog2(WDOG_CYC + 1);
   logic [CW-1:0] wdog_q;
   logic          timeout_q;

   // Counts consecutive HOLD cycles in which the owner has nothing to send.
   assign wdog_hit = (state_q == ST_HOLD) && !g_req && (wdog_q == CW'(WDOG_CYC - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wdog_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= wdog_hit;
         if ((state_q == ST_HOLD) && !g_req && !wdog_hit) wdog_q <= wdog_q + 1'b1;
         else                                             wdog_q <= '0;
      end
   end

   assign timeout = timeout_q;
`else
   assign wdog_hit = 1'b0;
   assign timeout  = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               state_d = ST_XFER;
               g_d     = pick_idx;
            end
         end
         ST_XFER: begin
            if (done) begin
               if (g_lock) begin
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_IDLE;
                  ptr_d   = g_q;
               end
            end
         end
         ST_HOLD: begin
            if (g_req) begin
               state_d = ST_XFER;
            end else if (wdog_hit || !g_lock) begin
               state_d = ST_IDLE;
               ptr_d   = g_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         g_q     <= '0;
         ptr_q   <= PW'(N_REQ - 1);
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule

// File: doc/dcp_tx_arb.md
DCP_TX_ARB -- requirements
Module: dcp_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of command units sharing the PRINT serializer, legal 2..8.
REQ-002 Parameter DW, default 32: width of the print data word.
REQ-003 Parameter WDOG_CYC, default 1024: hold-timeout length in clk cycles; used only when DCP_TXARB_WDOG_EN is defined.
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 req  in  N_REQ  per-unit print request; held high until that unit's ack.
REQ-007 lock  in  N_REQ  per-unit hold; keeps the grant across multiple words.
REQ-008 type  in  N_REQ  per-unit print type bit, passed through to PRINT.
REQ-009 dout  in  N_REQ*DW  per-unit data; unit i occupies bits [i*DW +: DW].
REQ-010 ack  out  N_REQ  per-unit one-cycle completion pulse.
REQ-011 grant  out  N_REQ  one-hot current owner; all zero when idle.
REQ-012 req_tx  out  1  request to PRINT.
REQ-013 type_tx  out  1  type bit to PRINT.
REQ-014 dout_tx  out  DW  data to PRINT.
REQ-015 ack_tx  in  1  one-cycle completion pulse from PRINT.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 timeout  out  1  one-cycle watchdog-release pulse; constant 0 when the watchdog is compiled out.

Function
REQ-018 FSM states: IDLE, XFER, HOLD; encoding is free.
REQ-019 IDLE, any req high: register a one-hot grant to the first requesting unit after ptr, searching upward and wrapping; go to XFER next cycle (1-cycle arbitration latency).
REQ-020 XFER: req_tx = req[g]; type_tx = type[g]; dout_tx = dout[g]; all three are combinational from the granted unit.
REQ-021 Outside XFER: req_tx = 0, type_tx = 0, dout_tx = 0.
REQ-022 ack[g] = ack_tx while in XFER; ack is 0 in all other states and for all non-granted units.
REQ-023 XFER with ack_tx and lock[g]=1: go to HOLD.
REQ-024 XFER with ack_tx and lock[g]=0: go to IDLE, set ptr <= g, clear grant.
REQ-025 HOLD with req[g]=1: go to XFER next cycle; no re-arbitration occurs.
REQ-026 HOLD with req[g]=0 and lock[g]=0: go to IDLE, set ptr <= g, clear grant.
REQ-027 ack_tx outside XFER is ignored.
REQ-028 Requests from non-granted units are ignored until the FSM returns to IDLE; no starvation under round-robin.
REQ-029 Simultaneous release (end of XFER or HOLD) and new requests: the new request is arbitrated in the following IDLE cycle; IDLE lasts at least one cycle.
REQ-030 A granted unit dropping req in XFER before ack is a protocol violation; req_tx follows req[g], and no ack is generated while req[g] is low.

Reset
REQ-031 rstn low, asynchronous: state IDLE; grant, ack, req_tx, type_tx, dout_tx, timeout and busy all 0; ptr = N_REQ-1, so unit 0 has first priority; watchdog counter 0.
REQ-032 Reset mid-XFER: abandon the transfer with no ack; after reset, PRINT sees req_tx = 0.

Configuration
REQ-033 With DCP_TXARB_WDOG_EN defined, a counter runs while in HOLD with req[g]=0 and clears on any other state or on req[g]=1.
REQ-034 When that counter reaches WDOG_CYC-1: pulse timeout for one cycle, go to IDLE, set ptr <= g, clear grant, regardless of lock[g].
REQ-035 Without DCP_TXARB_WDOG_EN: no counter logic exists, timeout is tied to 0, and HOLD may last indefinitely.

Structure
REQ-036 Shared package dcp_pkg holds the FSM state typedef, the default N_REQ/DW constants and the command-unit index constants (D, I, R, P, T, B, G, L).
REQ-037 One sub-module, rr_pick: combinational round-robin one-hot picker taking req and ptr and producing a one-hot result; the rest of the logic is flat.

Verification
REQ-038 Directed scenarios a bench must cover:
- After reset, req = 4'b0110: grant = 4'b0010 on cycle 2; req_tx = 1 with dout_tx = dout[1]; ack_tx pulse -> ack = 4'b0010 in the same cycle, then IDLE.
- All four units request continuously, lock = 0: grants rotate 0, 1, 2, 3, 0; each grant gets exactly one ack per ack_tx.
- Unit 2 with lock = 1 sends 3 words while units 0 and 3 request: grant stays 4'b0100 through all 3 acks; after lock drops, the next grant is unit 3, then unit 0.
- rstn pulsed low mid-XFER with unit 1 granted: same cycle, req_tx = 0, grant = 0, ack = 0; after release, unit 0 is served first.
- With DCP_TXARB_WDOG_EN and WDOG_CYC = 16: unit 0 holds lock, req = 0 -> timeout pulses after 16 HOLD cycles, grant = 0, and unit 1's pending request is granted 2 cycles later.
- Without the macro, same stimulus: grant stays 4'b0001 for 1000 cycles and timeout stays 0.
